// File: rtl/mem_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory access controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } mem_state_t;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  function automatic logic is_mem_op(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory req/gnt/rvalid bus between the MEM-stage controller and memory.
interface mem_stage_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/wdog_counter.sv
// Watchdog for outstanding memory accesses: counts enabled cycles since the
// last clear and flags the cycle in which the count reaches LIMIT.
module wdog_counter #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Fires in the LIMIT-th enabled cycle, i.e. the edge that would take the count to LIMIT.
  always_comb begin
    expired = en && (count_q == CNT_W'(LIMIT - 1));
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory access controller: sequences loads/stores over the
// req/gnt/rvalid bus, stalls the upstream pipeline and bubbles MEM_WB meanwhile.
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] RDATA_ERR      = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_mem,
  input  logic              mem_write_mem,
  input  logic [ADDR_W-1:0] addr_mem,
  input  logic [DATA_W-1:0] wdata_mem,
  mem_stage_ctrl_if.master  dmem,
  output logic              stall,
  output logic              wb_bubble,
  output logic [DATA_W-1:0] read_data_mem,
  output logic              timeout_err
);

  mem_state_t        state_q, state_d;
  logic [DATA_W-1:0] rdata_q;
  logic              mem_op;
  logic              req_c, busy_c;
  logic              capture_c, abort_c;
  logic              wd_clr, wd_en, wd_expired;

  wdog_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    mem_op = is_mem_op(mem_read_mem, mem_write_mem);
    wd_clr = (state_q == IDLE);
    wd_en  = (state_q == REQ) || (state_q == WAIT_R);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_c     = 1'b0;
    busy_c    = 1'b0;
    capture_c = 1'b0;
    abort_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          req_c  = 1'b1;
          busy_c = 1'b1;
          if (dmem.dmem_gnt) begin
            state_d = mem_write_mem ? DONE : WAIT_R;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        req_c  = 1'b1;
        busy_c = 1'b1;
        // Watchdog abort wins over a grant landing in the same cycle.
        if (wd_expired) begin
          abort_c = 1'b1;
          state_d = DONE;
        end else if (dmem.dmem_gnt) begin
          state_d = mem_write_mem ? DONE : WAIT_R;
        end
      end
      WAIT_R: begin
        busy_c = 1'b1;
        if (wd_expired) begin
          abort_c = 1'b1;
          state_d = DONE;
        end else if (dmem.dmem_rvalid) begin
          capture_c = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q     <= '0;
      timeout_err <= 1'b0;
    end else if (abort_c) begin
      rdata_q     <= RDATA_ERR;
      timeout_err <= 1'b1;
    end else if (capture_c) begin
      rdata_q <= dmem.dmem_rdata;
    end
  end

  // Reset drops the handshake and releases the pipeline at once, even with an op still present.
  always_comb begin
    dmem.dmem_req = req_c & ~reset;
    stall         = busy_c & ~reset;
    wb_bubble     = busy_c & ~reset;
  end

  assign dmem.dmem_we    = mem_write_mem;
  assign dmem.dmem_addr  = addr_mem;
  assign dmem.dmem_wdata = wdata_mem;
  assign read_data_mem   = rdata_q;

endmodule
